rtc_bus_responder: RTL and testbench
====================================

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter: TICK_DIV, default 100000000, clk cycles per one-second tick (must be >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock; all logic is on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: CS  input  1  chip select, active-low.
REQ-005 SHALL have port: AD  input  1  0 = address phase, 1 = data phase.
REQ-006 SHALL have port: WR  input  1  write strobe, active-low.
REQ-007 SHALL have port: RD  input  1  read strobe, active-low.
REQ-008 SHALL have port: RTC_BUS  inout  8  multiplexed address/data bus; driven only while bus_oe=1, else high-Z.
REQ-009 SHALL have port: tick  output  1  one-cycle pulse on every one-second tick.
REQ-010 SHALL have port: addr_pr  output  8  currently latched register address.

Function
REQ-011 SHALL pass CS, AD, WR and RD through 2-FF synchronizers; all decoding SHALL use the synchronized copies.
REQ-012 SHALL run an FSM with states IDLE, ADDR, WDATA and RDATA.
REQ-013 IDLE->ADDR when CS=0, AD=0, WR=0, RD=1; on the synced WR rising edge, SHALL latch RTC_BUS into addr_pr and return to IDLE.
REQ-014 IDLE->WDATA when CS=0, AD=1, WR=0, RD=1; on the synced WR rising edge, SHALL write RTC_BUS to reg[addr_pr] and return to IDLE.
REQ-015 IDLE->RDATA when CS=0, AD=1, RD=0, WR=1.
REQ-016 On RDATA entry, SHALL snapshot reg[addr_pr] into dout and assert bus_oe the following cycle.
REQ-017 SHALL keep dout stable for the whole RDATA phase, even if a tick occurs.
REQ-018 SHALL leave RDATA when synced RD=1 or CS=1, with bus_oe=0 on that same cycle.
REQ-019 WR=0 and RD=0 together SHALL be ignored: the FSM stays or returns to IDLE, with no write and no drive.
REQ-020 CS rising during ADDR or WDATA SHALL abort to IDLE without latching or writing.
REQ-021 Register map: 0x21 seconds, 0x22 minutes, 0x23 hours (24 h), 0x24 day, 0x25 month, 0x26 year, all BCD; 0x41-0x43 timer sec/min/hour; 0x00 control.
REQ-022 Reads of unmapped addresses SHALL return 0x00; writes to unmapped addresses SHALL be ignored.
REQ-023 SHALL keep an internal prescaler that counts 0..TICK_DIV-1 and pulses tick for one cycle when it wraps.
REQ-024 SHALL freeze the prescaler (no count, no tick) while control bit 0 = 1.
REQ-025 BCD increment rule: if value >= limit, next = 0x00; else if low nibble >= 9, next = {high+1, 0}; else next = value+1.
REQ-026 BCD limits SHALL be seconds 0x59, minutes 0x59, hours 0x23.
REQ-027 Day, month and year SHALL never increment on their own.
REQ-028 If a bus write targets a time register in the same cycle as a tick, the bus write SHALL win and that register's increment SHALL be dropped; carries into other registers proceed.

Reset
REQ-029 On reset=1 at a rising clk edge: all registers 0x00, addr_pr=0x00, dout=0x00, bus_oe=0, tick=0, prescaler=0, FSM=IDLE, synchronizers loaded with 1.
REQ-030 Reset asserted mid-read SHALL release RTC_BUS on the next clk edge.

Configuration
REQ-031 Macro RTC_RESP_TIMEKEEP_EN: when defined, SHALL include the prescaler, tick generation and BCD time advance.
REQ-032 When RTC_RESP_TIMEKEEP_EN is undefined: tick SHALL be tied to 0, no prescaler SHALL exist, and time registers change only by bus writes; all bus behaviour is unchanged.

Verification
REQ-033 Reset, then address 0x22 and write 0x37 -> read of 0x22 returns 0x37; RTC_BUS is Z outside RD-low windows.
REQ-034 With TICK_DIV=100 and the macro defined, write 0x23/0x59/0x59 to hours/minutes/seconds -> after 1 tick, reads return 0x00/0x00/0x00 and day is unchanged.
REQ-035 Seconds=0x09, one tick -> 0x10; seconds=0x59, one tick -> 0x00 and minutes +1.
REQ-036 Read of address 0x7F -> returns 0x00; a write of 0xAA to 0x7F leaves all mapped registers unchanged.
REQ-037 Assert WR and RD low together with AD=1 -> no register change and RTC_BUS stays Z.
REQ-038 Pulse reset during a read of 0x21 -> RTC_BUS is Z by the next clk edge; all registers read 0x00 afterwards.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: an RTC register file reached over a CS/AD/WR/RD bus.
// The bus multiplexes an 8-bit address and data, and RTC_BUS is bidirectional.
// Define RTC_RESP_TIMEKEEP_EN to add the one-second prescaler, the tick pulse
// and BCD advance of seconds, minutes and hours. Without that macro the time
// registers change only through bus writes, and tick stays low.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       AD,
    input  logic       WR,
    input  logic       RD,
    inout  wire  [7:0] RTC_BUS,
    output logic       tick,
    output logic [7:0] addr_pr
);

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

    if (TICK_DIV < 2) begin : g_tick_div_check
        $error("rtc_bus_responder: TICK_DIV must be at least 2");
    end

    logic [3:0] sync1_q, sync2_q;
    logic       cs_s, ad_s, wr_s, rd_s;
    state_t     state_q;
    logic [7:0] addr_q, dout_q, rd_data;
    logic       bus_oe_q, wr_fire;
    logic [7:0] ctrl_q, sec_q, min_q, hour_q, day_q, mon_q, year_q;
    logic [7:0] tsec_q, tmin_q, thour_q;

    // Two-stage synchronizers for the asynchronous strobes. They reset to 1,
    // which is the idle level of every strobe.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {CS, AD, WR, RD};
            sync2_q <= sync1_q;
        end
    end

    assign {cs_s, ad_s, wr_s, rd_s} = sync2_q;

    // A data write commits on the synchronized WR rising edge. It is
    // suppressed when the phase is aborted by CS or by RD and WR both being low.
    assign wr_fire = (state_q == WDATA) && !cs_s && rd_s && wr_s;

    // Bus phase FSM. It latches the address, snapshots read data and
    // registers the bus output enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 8'h00;
            dout_q   <= 8'h00;
            bus_oe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bus_oe_q <= 1'b0;
                    if (!cs_s && !wr_s && rd_s) begin
                        state_q <= ad_s ? WDATA : ADDR;
                    end else if (!cs_s && ad_s && !rd_s && wr_s) begin
                        state_q <= RDATA;
                        dout_q  <= rd_data;
                    end
                end
                ADDR: begin
                    if (cs_s || !rd_s) begin
                        state_q <= IDLE;
                    end else if (wr_s) begin
                        addr_q  <= RTC_BUS;
                        state_q <= IDLE;
                    end
                end
                WDATA: begin
                    if (cs_s || !rd_s || wr_s) begin
                        state_q <= IDLE;
                    end
                end
                RDATA: begin
                    if (cs_s || rd_s || !wr_s) begin
                        state_q  <= IDLE;
                        bus_oe_q <= 1'b0;
                    end else begin
                        bus_oe_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign RTC_BUS = bus_oe_q ? dout_q : 8'hzz;
    assign addr_pr = addr_q;

`ifdef RTC_RESP_TIMEKEEP_EN
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic          tick_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v >= lim) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'h0};
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Prescaler. It counts 0..TICK_DIV-1 and pulses tick on the wrap.
    // Control bit 0 freezes the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (ctrl_q[0]) begin
            tick_q  <= 1'b0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
        end else begin
            presc_q <= presc_q + PW'(1);
            tick_q  <= 1'b0;
        end
    end

    assign tick = tick_q;
`else
    assign tick = 1'b0;
`endif

    // Register file. The time advance comes first. A bus write in the same
    // cycle overrides only the register it targets.
    always_ff @(posedge clk) begin
        // NOTE: every register has an explicit reset because software expects all registers to read zero after reset.
        if (reset) begin
            ctrl_q  <= 8'h00;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= 8'h00;
            day_q   <= 8'h00;
            mon_q   <= 8'h00;
            year_q  <= 8'h00;
            tsec_q  <= 8'h00;
            tmin_q  <= 8'h00;
            thour_q <= 8'h00;
        end else begin
`ifdef RTC_RESP_TIMEKEEP_EN
            if (tick_q) begin
                sec_q <= bcd_inc(sec_q, 8'h59);
                if (sec_q >= 8'h59) begin
                    min_q <= bcd_inc(min_q, 8'h59);
                    if (min_q >= 8'h59) begin
                        hour_q <= bcd_inc(hour_q, 8'h23);
                    end
                end
            end
`endif
            if (wr_fire) begin
                case (addr_q)
                    8'h00:   ctrl_q  <= RTC_BUS;
                    8'h21:   sec_q   <= RTC_BUS;
                    8'h22:   min_q   <= RTC_BUS;
                    8'h23:   hour_q  <= RTC_BUS;
                    8'h24:   day_q   <= RTC_BUS;
                    8'h25:   mon_q   <= RTC_BUS;
                    8'h26:   year_q  <= RTC_BUS;
                    8'h41:   tsec_q  <= RTC_BUS;
                    8'h42:   tmin_q  <= RTC_BUS;
                    8'h43:   thour_q <= RTC_BUS;
                    default: ;
                endcase
            end
        end
    end

    // Read decode. Unmapped addresses read as zero.
    always_comb begin
        // NOTE: rd_data gets a default before the case so that no latch is inferred.
        rd_data = 8'h00;
        case (addr_q)
            8'h00:   rd_data = ctrl_q;
            8'h21:   rd_data = sec_q;
            8'h22:   rd_data = min_q;
            8'h23:   rd_data = hour_q;
            8'h24:   rd_data = day_q;
            8'h25:   rd_data = mon_q;
            8'h26:   rd_data = year_q;
            8'h41:   rd_data = tsec_q;
            8'h42:   rd_data = tmin_q;
            8'h43:   rd_data = thour_q;
            default: rd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Testbench for rtc_bus_responder. Stimulus tasks drive bus cycles and push
// expected observations into a queue. A monitor on the falling edge pops each
// expectation and compares it with the DUT output. The reference model is an
// array of register contents plus integer clock arithmetic.
// A pull-up on RTC_BUS makes a released bus read back as 0xFF.
module tb_rtc_bus_responder;

    localparam int TICK_DIV = 100;

    typedef enum int {K_BUS, K_ADDR, K_TICKS} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CS = 1'b1, AD = 1'b1, WR = 1'b1, RD = 1'b1;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dat = 8'h00;
    wire  [7:0] RTC_BUS;
    logic       tick;
    logic [7:0] addr_pr;

    exp_t       exp_q[$];
    logic       strobe = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         tick_cnt = 0;

    logic [7:0] mem [256];
    logic [7:0] m_addr;
    logic [7:0] mapped_list [10] = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h24,
                                     8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    assign RTC_BUS = tb_oe ? tb_dat : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (RTC_BUS[i]);
    end

    rtc_bus_responder #(.TICK_DIV(TICK_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .CS      (CS),
        .AD      (AD),
        .WR      (WR),
        .RD      (RD),
        .RTC_BUS (RTC_BUS),
        .tick    (tick),
        .addr_pr (addr_pr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick === 1'b1) tick_cnt++;
    end

    // Monitor: pops the next expectation whenever the driver raises the strobe.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (strobe) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: observation without expectation");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_BUS:   act = {24'h0, RTC_BUS};
                    K_ADDR:  act = {24'h0, addr_pr};
                    default: act = tick_cnt;
                endcase
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", e.tag, act, e.val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit is_mapped(input logic [7:0] a);
        return (a == 8'h00) || (a >= 8'h21 && a <= 8'h26) || (a >= 8'h41 && a <= 8'h43);
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        return is_mapped(a) ? mem[a] : 8'h00;
    endfunction

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int i);
        return 8'((i / 10) * 16 + (i % 10));
    endfunction

    // One second of wall-clock time on a 24 h clock.
    function automatic void model_tick();
        int s, m, h;
        s = bcd2i(mem[8'h21]);
        m = bcd2i(mem[8'h22]);
        h = bcd2i(mem[8'h23]);
        s = s + 1;
        if (s >= 60) begin
            s = 0;
            m = m + 1;
            if (m >= 60) begin
                m = 0;
                h = (h + 1) % 24;
            end
        end
        mem[8'h21] = i2bcd(s);
        mem[8'h22] = i2bcd(m);
        mem[8'h23] = i2bcd(h);
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input kind_e k, input logic [31:0] v, input string tag);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1 strobe = 1'b1;
        @(negedge clk);
        #1 strobe = 1'b0;
    endtask

    task automatic idle_bus();
        CS = 1'b1; AD = 1'b1; WR = 1'b1; RD = 1'b1; tb_oe = 1'b0;
    endtask

    task automatic bus_write(input logic is_data, input logic [7:0] v);
        CS = 1'b0; AD = is_data; WR = 1'b0; RD = 1'b1; tb_dat = v; tb_oe = 1'b1;
        wait_cyc(4);
        WR = 1'b1;
        wait_cyc(4);
        idle_bus();
        wait_cyc(3);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] v);
        bus_write(1'b0, a);
        m_addr = a;
        bus_write(1'b1, v);
        if (is_mapped(a)) mem[a] = v;
    endtask

    // A read of the currently latched address, plus a check that the bus is released afterwards.
    task automatic bus_read_check(input string tag);
        CS = 1'b0; AD = 1'b1; RD = 1'b0; WR = 1'b1; tb_oe = 1'b0;
        wait_cyc(5);
        expect_out(K_BUS, {24'h0, model_read(m_addr)}, tag);
        idle_bus();
        wait_cyc(4);
        expect_out(K_BUS, 32'hFF, {tag, "_released"});
    endtask

    task automatic reg_read(input logic [7:0] a, input string tag);
        bus_write(1'b0, a);
        m_addr = a;
        bus_read_check(tag);
    endtask

    task automatic one_tick();
        int c0;
        int budget;
        c0 = tick_cnt;
        reg_write(8'h00, 8'h00);
        budget = 0;
        while (tick_cnt == c0 && budget < 300) begin
            @(posedge clk);
            budget++;
        end
        #1;
        reg_write(8'h00, 8'h01);
        model_tick();
        expect_out(K_TICKS, c0 + 1, "one_tick_count");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        m_addr = 8'h00;
        idle_bus();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state. Seconds are read before the prescaler could tick.
        expect_out(K_ADDR, 32'h00, "rst_addr_pr");
        expect_out(K_BUS, 32'hFF, "rst_bus_released");
        reg_read(8'h21, "rst_seconds");
        reg_write(8'h00, 8'h01);
        for (int i = 0; i < 10; i++) begin
            if (mapped_list[i] != 8'h21) reg_read(mapped_list[i], $sformatf("rst_reg_%0h", mapped_list[i]));
        end

        // Basic write then read-back of minutes.
        reg_write(8'h22, 8'h37);
        expect_out(K_ADDR, 32'h22, "addr_latch_22");
        bus_read_check("minutes_37");

        // Unmapped address: reads as zero, and a write leaves the map untouched.
        reg_read(8'h7F, "unmapped_read");
        reg_write(8'h7F, 8'hAA);
        for (int i = 0; i < 10; i++) reg_read(mapped_list[i], $sformatf("after_unmapped_%0h", mapped_list[i]));

        // WR and RD low together in the data phase: no write and no drive.
        reg_write(8'h42, 8'h5A);
        CS = 1'b0; AD = 1'b1; WR = 1'b0; RD = 1'b0; tb_oe = 1'b0;
        wait_cyc(6);
        expect_out(K_BUS, 32'hFF, "wr_rd_both_low_released");
        idle_bus();
        wait_cyc(4);
        bus_read_check("wr_rd_both_low_nochange");

        // CS rises during the data phase: the write is aborted.
        reg_write(8'h41, 8'h11);
        CS = 1'b0; AD = 1'b1; WR = 1'b0; RD = 1'b1; tb_dat = 8'h99; tb_oe = 1'b1;
        wait_cyc(4);
        CS = 1'b1;
        wait_cyc(4);
        WR = 1'b1;
        wait_cyc(4);
        idle_bus();
        wait_cyc(2);
        bus_read_check("wdata_abort_nochange");

        // CS rises during the address phase: the address latch keeps its old value.
        CS = 1'b0; AD = 1'b0; WR = 1'b0; RD = 1'b1; tb_dat = 8'h23; tb_oe = 1'b1;
        wait_cyc(4);
        CS = 1'b1;
        wait_cyc(4);
        WR = 1'b1;
        wait_cyc(4);
        idle_bus();
        wait_cyc(2);
        expect_out(K_ADDR, {24'h0, m_addr}, "addr_abort_keep");
        bus_read_check("addr_abort_read");

        // Random traffic against the model. Control writes keep the prescaler frozen.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a;
            logic [7:0] d;
            int         pick;
            pick = $urandom_range(0, 12);
            if (pick < 10) a = mapped_list[pick];
            else a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
`ifdef RTC_RESP_TIMEKEEP_EN
            if (a == 8'h00) d[0] = 1'b1;
`endif
            if ($urandom_range(0, 1) == 1) reg_write(a, d);
            else reg_read(a, $sformatf("rand_read_%0h", a));
        end

`ifdef RTC_RESP_TIMEKEEP_EN
        // Full-day rollover. Day is unaffected.
        reg_write(8'h24, 8'h15);
        reg_write(8'h23, 8'h23);
        reg_write(8'h22, 8'h59);
        reg_write(8'h21, 8'h59);
        one_tick();
        reg_read(8'h23, "rollover_hours");
        reg_read(8'h22, "rollover_minutes");
        reg_read(8'h21, "rollover_seconds");
        reg_read(8'h24, "rollover_day");
        // Low nibble carry.
        reg_write(8'h21, 8'h09);
        one_tick();
        reg_read(8'h21, "sec_09_to_10");
        // Seconds wrap carries into minutes.
        reg_write(8'h22, 8'h12);
        reg_write(8'h21, 8'h59);
        one_tick();
        reg_read(8'h21, "sec_59_wrap");
        reg_read(8'h22, "min_carry");
        // Frozen prescaler produces no ticks.
        begin
            int c1;
            c1 = tick_cnt;
            wait_cyc(250);
            expect_out(K_TICKS, c1, "frozen_no_tick");
        end
`else
        // Without timekeeping, tick never pulses and time holds.
        reg_write(8'h21, 8'h59);
        wait_cyc(300);
        expect_out(K_TICKS, 32'h0, "tick_tied_low");
        reg_read(8'h21, "time_static");
`endif

        // Reset during a read of seconds releases the bus on the next edge.
        reg_write(8'h21, 8'h42);
        bus_write(1'b0, 8'h21);
        m_addr = 8'h21;
        CS = 1'b0; AD = 1'b1; RD = 1'b0; WR = 1'b1; tb_oe = 1'b0;
        wait_cyc(5);
        expect_out(K_BUS, 32'h42, "pre_reset_read");
        @(posedge clk);
        #1 reset = 1'b1;
        expect_out(K_BUS, 32'hFF, "reset_releases_bus");
        idle_bus();
        wait_cyc(3);
        reset = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
        m_addr = 8'h00;
        expect_out(K_ADDR, 32'h00, "post_reset_addr_pr");
        reg_read(8'h21, "post_reset_seconds");
        for (int i = 0; i < 10; i++) begin
            if (mapped_list[i] != 8'h21) reg_read(mapped_list[i], $sformatf("post_reset_%0h", mapped_list[i]));
        end

        wait_cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
